inv_arbiter: RTL and testbench



---
 rtl/inv_arbiter.sv | 165 ++++++++++++++++
 tb/tb_inv_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_arbiter.sv
// Round-robin arbiter that shares one modular-inverse unit among N_REQ
// requesters, with a watchdog that aborts an operation whose done never comes.
module inv_arbiter #(
    parameter int WIDTH       = 256,
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0]       P,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH:0]         result,
    output logic                   err,
    output logic                   busy,
    output logic                   inv_start,
    output logic [WIDTH-1:0]       inv_a,
    input  logic                   inv_done,
    input  logic [WIDTH:0]         inv_result
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = IW + 1;
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [WIDTH:0]    result_q, result_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic [WIDTH-1:0]  inv_a_q, inv_a_d;

    logic [IW-1:0]     sel;
    logic [PW-1:0]     pos;
    logic [WIDTH-1:0]  sel_a;

    // The modulus goes straight to the inverter; nothing here needs it.
    logic unused_p;
    assign unused_p = ^P;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] v);
        onehot = '0;
        onehot[v] = 1'b1;
    endfunction

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        sel = '0;
        pos = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = PW'(ptr_q) + PW'(k);
            if (pos >= PW'(N_REQ)) pos = pos - PW'(N_REQ);
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && pos == PW'(i)) sel = IW'(i);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == IW'(i)) sel_a = req_a[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        wdog_d   = wdog_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        start_d  = 1'b0;
        inv_a_d  = inv_a_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    idx_d   = sel;
                    gnt_d   = onehot(sel);
                    inv_a_d = sel_a;
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (inv_done) begin
                    result_d = inv_result;
                    ack_d    = onehot(idx_q);
                    state_d  = S_RESP;
                end else if (wdog_q == WD_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    ack_d    = onehot(idx_q);
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            wdog_q   <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            inv_a_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            wdog_q   <= wdog_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            inv_a_q  <= inv_a_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign inv_start = start_q;
    assign inv_a     = inv_a_q;

endmodule

// File: tb/tb_inv_arbiter.sv
// Randomized scoreboard bench for inv_arbiter with a behavioural inverter
// and an abstract round-robin service-order model.
`timescale 1ns/1ps
module tb_inv_arbiter;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int TO   = 16;
    localparam int PMOD = 23;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [W-1:0]   P;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W:0]     result;
    logic           err;
    logic           busy;
    logic           inv_start;
    logic [W-1:0]   inv_a;
    logic           inv_done;
    logic [W:0]     inv_result;

    inv_arbiter #(
        .WIDTH(W),
        .N_REQ(N),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_a(req_a),
        .P(P),
        .gnt(gnt),
        .ack(ack),
        .result(result),
        .err(err),
        .busy(busy),
        .inv_start(inv_start),
        .inv_a(inv_a),
        .inv_done(inv_done),
        .inv_result(inv_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int res;
        bit err;
    } exp_t;

    typedef struct {
        int op;
        int lat;
    } spec_t;

    exp_t  expq[$];
    int    latq[$];
    int    opq[N][$];
    spec_t plan[N][$];
    int    ack_log[$];
    int    res_log[$];
    int    t_req[N];
    int    t_start = -1;
    int    t_ack = -1;
    int    t_bfall = -1;
    int    model_ptr = 0;
    bit    kill = 1'b0;
    bit    withdraw[N];
    int    checks = 0;
    int    errors = 0;

    function automatic int modinv(input int a);
        for (int x = 1; x < PMOD; x++) begin
            if ((a * x) % PMOD == 1) return x;
        end
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_log(input string nm, input int got[$], input int want[$]);
        chk({nm, "_count"}, got.size(), want.size());
        for (int k = 0; k < want.size(); k++) begin
            if (k < got.size()) chk($sformatf("%s[%0d]", nm, k), got[k], want[k]);
        end
    endtask

    task automatic add(input int r, input int op, input int lat);
        spec_t s;
        s.op  = op;
        s.lat = lat;
        plan[r].push_back(s);
    endtask

    function automatic int rl();
        return int'($urandom_range(1, TO));
    endfunction

    // Service order: nearest pending requester at or after the pointer;
    // a requester with more work is pending again at the next selection.
    task automatic issue();
        int   k[N];
        int   p;
        int   total;
        int   i;
        int   c;
        bit   found;
        spec_t s;
        exp_t e;
        total = 0;
        for (int r = 0; r < N; r++) begin
            k[r] = 0;
            total += plan[r].size();
        end
        p = model_ptr;
        for (int t = 0; t < total; t++) begin
            i = 0;
            found = 1'b0;
            for (int d = 0; d < N; d++) begin
                c = (p + d) % N;
                if (!found && k[c] < plan[c].size()) begin
                    i = c;
                    found = 1'b1;
                end
            end
            s = plan[i][k[i]];
            e.idx = i;
            e.err = (s.lat == 0 || s.lat > TO);
            e.res = e.err ? 0 : modinv(s.op);
            expq.push_back(e);
            latq.push_back(s.lat);
            k[i]++;
            p = (i + 1) % N;
        end
        model_ptr = p;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < plan[r].size(); j++) opq[r].push_back(plan[r][j].op);
            plan[r].delete();
        end
    endtask

    function automatic bit pend();
        for (int r = 0; r < N; r++) begin
            if (opq[r].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic flush();
        expq.delete();
        latq.delete();
        for (int r = 0; r < N; r++) opq[r].delete();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((expq.size() != 0 || busy || req != 0 || pend()) && n < 800) begin
            @(negedge clk);
            n++;
        end
        if (n >= 800) begin
            checks++;
            errors++;
            $display("FAIL %s_stall: %0d responses outstanding after %0d cycles",
                     nm, expq.size(), n);
            flush();
        end
        repeat (2) @(negedge clk);
    endtask

    // Requesters: assert while work is queued, drop on ack, optional withdraw.
    initial begin
        req   = '0;
        req_a = '0;
        for (int r = 0; r < N; r++) begin
            t_req[r]    = -1;
            withdraw[r] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (kill) begin
                    req[i] = 1'b0;
                end else if (ack[i]) begin
                    req[i] = 1'b0;
                    if (opq[i].size() != 0) void'(opq[i].pop_front());
                end else if (req[i] && gnt[i] && withdraw[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && !gnt[i] && opq[i].size() != 0) begin
                    req[i] = 1'b1;
                    req_a[i*W +: W] = W'(opq[i][0]);
                    t_req[i] = cyc;
                end
            end
        end
    end

    // Behavioural inverter: done lat cycles after start; lat 0 never answers.
    initial begin
        int a;
        int lat;
        bit aborted;
        inv_done   = 1'b0;
        inv_result = '0;
        forever begin
            @(negedge clk);
            if (reset_n && inv_start) begin
                a   = int'(inv_a);
                lat = (latq.size() != 0) ? latq.pop_front() : 1;
                if (lat != 0) begin
                    aborted = 1'b0;
                    for (int c = 0; c < lat; c++) begin
                        @(posedge clk);
                        if (!reset_n) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    if (!aborted) begin
                        #1;
                        inv_done   = 1'b1;
                        inv_result = (W+1)'(modinv(a));
                        @(posedge clk);
                        #1;
                        inv_done = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pop and compare on every ack.
    initial begin
        bit   prev_busy;
        int   id;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (inv_start) t_start = cyc;
            if (prev_busy && !busy) t_bfall = cyc;
            prev_busy = busy;
            if (reset_n && err && ack == '0) begin
                checks++;
                errors++;
                $display("FAIL err_without_ack: err=1 ack=%b", ack);
            end
            if (reset_n && ack != '0) begin
                t_ack = cyc;
                id = -1;
                for (int i = 0; i < N; i++) if (ack[i]) id = i;
                ack_log.push_back(id);
                res_log.push_back(int'(result));
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack=%b with nothing outstanding", ack);
                end else begin
                    e = expq.pop_front();
                    chk("ack_vec", ack, 64'(1) << e.idx);
                    chk("gnt_at_ack", gnt, 64'(1) << e.idx);
                    chk($sformatf("result_req%0d", e.idx), result, e.res);
                    chk($sformatf("err_req%0d", e.idx), err, e.err);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_gnt"}, gnt, 0);
        chk({nm, "_ack"}, ack, 0);
        chk({nm, "_result"}, result, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_inv_start"}, inv_start, 0);
        chk({nm, "_inv_a"}, inv_a, 0);
    endtask

    initial begin
        int want[$];
        int n;
        int cnt;
        P       = W'(PMOD);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round robin from pointer 0
        ack_log.delete(); res_log.delete();
        add(0, 3, rl()); add(0, 3, rl());
        add(1, 5, rl()); add(2, 7, rl()); add(3, 9, rl());
        issue();
        wait_idle("rr");
        want = '{0, 1, 2, 3, 0}; chk_log("rr_order", ack_log, want);
        want = '{8, 14, 10, 18, 8}; chk_log("rr_result", res_log, want);

        // Single request latency
        ack_log.delete(); res_log.delete();
        add(0, 3, 10);
        issue();
        wait_idle("single");
        chk("single_start_lat", t_start - t_req[0], 1);
        chk("single_ack_lat", t_ack - t_start, 11);
        chk("single_busy_fall", t_bfall - t_ack, 1);
        want = '{8}; chk_log("single_result", res_log, want);

        // Pointer skip: after 1 is served, 0 beats 1
        ack_log.delete();
        add(1, 5, rl());
        issue();
        wait_idle("skip_a");
        add(0, 7, rl()); add(1, 9, rl());
        issue();
        wait_idle("skip_b");
        want = '{1, 0, 1}; chk_log("skip_order", ack_log, want);

        // Withdraw after grant still completes
        ack_log.delete(); res_log.delete();
        withdraw[2] = 1'b1;
        add(2, 13, 8); add(3, 4, rl());
        issue();
        wait_idle("withdraw");
        withdraw[2] = 1'b0;
        want = '{2, 3}; chk_log("withdraw_order", ack_log, want);
        want = '{16, 6}; chk_log("withdraw_result", res_log, want);

        // Done on the timeout cycle wins
        add(1, 6, TO);
        issue();
        wait_idle("tie");
        chk("tie_ack_lat", t_ack - t_start, TO + 1);

        // Timeout, then a late done is ignored
        ack_log.delete();
        add(3, 2, TO + 6);
        issue();
        wait_idle("timeout");
        chk("timeout_ack_lat", t_ack - t_start, TO + 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("late_done_busy", cnt, 0);
        chk("late_done_acks", ack_log.size(), 1);
        chk("late_done_result", result, 0);

        // Randomized phases
        for (int ph = 0; ph < 15; ph++) begin
            for (int r = 0; r < N; r++) begin
                n = int'($urandom_range(0, 2));
                for (int j = 0; j < n; j++) add(r, int'($urandom_range(1, PMOD - 1)), rl());
            end
            issue();
            wait_idle($sformatf("rand%0d", ph));
        end

        // Async reset in WAIT, then priority restarts at 0
        add(2, 17, rl());
        issue();
        wait_idle("pre_reset");
        add(1, 5, 0);
        issue();
        n = 0;
        while (!inv_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reset_launch_seen", inv_start, 1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        kill    = 1'b1;
        #1;
        chk_zero_outputs("async_reset");
        flush();
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        kill      = 1'b0;
        model_ptr = 0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (inv_start || busy) cnt++;
        end
        chk("no_restart_after_reset", cnt, 0);
        ack_log.delete();
        for (int r = 0; r < N; r++) add(r, r + 2, rl());
        issue();
        wait_idle("post_reset");
        want = '{0, 1, 2, 3}; chk_log("post_reset_order", ack_log, want);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
